// File: rtl/masked_add_arb.sv
// masked_add_arb
// Round-robin front end that shares one externally pipelined masked adder
// between two requesters. An accepted request is registered and presented
// on add_* in the next cycle. A {valid, id} tag then travels alongside the
// operation through the adder's LAT-cycle pipeline. When the tag reaches the
// last stage, add_sum is captured into the matching response register.
// Shares are only routed and never combined, so the masking stays intact.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   flush               synchronous discard of all in-flight operations
//   reqN_valid/ready    request handshake for requester N (N = 0, 1)
//   reqN_a0..b1, cin    operand shares and carry-in of requester N
//   add_a0..b1, add_cin registered shares driven to the shared adder
//   add_sum             adder result, LAT cycles after add_* were presented
//   rspN_valid/sum      one-cycle response pulse and held result for N
//   busy                an operation is in flight or a response is pending
//
// LAT must be at least 1.
module masked_add_arb #(
  parameter int LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a0,
  input  logic [3:0] req0_a1,
  input  logic [3:0] req0_b0,
  input  logic [3:0] req0_b1,
  input  logic       req0_cin,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a0,
  input  logic [3:0] req1_a1,
  input  logic [3:0] req1_b0,
  input  logic [3:0] req1_b1,
  input  logic       req1_cin,
  output logic [3:0] add_a0,
  output logic [3:0] add_a1,
  output logic [3:0] add_b0,
  output logic [3:0] add_b1,
  output logic       add_cin,
  input  logic [4:0] add_sum,
  output logic       rsp0_valid,
  output logic [4:0] rsp0_sum,
  output logic       rsp1_valid,
  output logic [4:0] rsp1_sum,
  output logic       busy
);

  logic         last_q, last_d;
  logic         grant0, grant1;
  logic         issue, issue_id;
  logic [3:0]   add_a0_q, add_a0_d;
  logic [3:0]   add_a1_q, add_a1_d;
  logic [3:0]   add_b0_q, add_b0_d;
  logic [3:0]   add_b1_q, add_b1_d;
  logic         add_cin_q, add_cin_d;
  logic [LAT:0] tag_v_q, tag_v_d;
  logic [LAT:0] tag_id_q, tag_id_d;
  logic         capture;
  logic         rsp0_valid_q, rsp0_valid_d;
  logic         rsp1_valid_q, rsp1_valid_d;
  logic [4:0]   rsp0_sum_q, rsp0_sum_d;
  logic [4:0]   rsp1_sum_q, rsp1_sum_d;

  // The grant goes to the requester that was not served last. The
  // last-grant pointer resets to 1, so req0 wins the first contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Only the outputs are gated by rst_n. Internally the flops are already
  // held in reset, so the reset net never reaches a data input.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign issue      = grant0 | grant1;
  assign issue_id   = grant1;

  always_comb begin
    last_d = issue ? issue_id : last_q;
  end

  // The operand register loads the granted shares and is all-zero otherwise.
  // No grant is given while flush is high, so flush also clears it.
  always_comb begin
    add_a0_d  = 4'd0;
    add_a1_d  = 4'd0;
    add_b0_d  = 4'd0;
    add_b1_d  = 4'd0;
    add_cin_d = 1'b0;
    if (grant0) begin
      add_a0_d  = req0_a0;
      add_a1_d  = req0_a1;
      add_b0_d  = req0_b0;
      add_b1_d  = req0_b1;
      add_cin_d = req0_cin;
    end else if (grant1) begin
      add_a0_d  = req1_a0;
      add_a1_d  = req1_a1;
      add_b0_d  = req1_b0;
      add_b1_d  = req1_b1;
      add_cin_d = req1_cin;
    end
  end

  // Stage 0 of the tag pipe is loaded together with the operand register.
  // Stage LAT is therefore valid in the cycle where add_sum carries the result.
  always_comb begin
    tag_v_d  = {tag_v_q[LAT-1:0], issue};
    tag_id_d = {tag_id_q[LAT-1:0], issue_id};
    if (flush) begin
      tag_v_d = '0;
    end
  end

  // The result is captured into the owner's response register. Flush also
  // suppresses the capture, so no discarded operation can still respond.
  always_comb begin
    capture      = tag_v_q[LAT] & ~flush;
    rsp0_valid_d = capture & ~tag_id_q[LAT];
    rsp1_valid_d = capture & tag_id_q[LAT];
    rsp0_sum_d   = rsp0_valid_d ? add_sum : rsp0_sum_q;
    rsp1_sum_d   = rsp1_valid_d ? add_sum : rsp1_sum_q;
  end

  // All state lives here; reset clears everything but the grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      add_a0_q     <= 4'd0;
      add_a1_q     <= 4'd0;
      add_b0_q     <= 4'd0;
      add_b1_q     <= 4'd0;
      add_cin_q    <= 1'b0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_sum_q   <= 5'd0;
      rsp1_sum_q   <= 5'd0;
    end else begin
      last_q       <= last_d;
      add_a0_q     <= add_a0_d;
      add_a1_q     <= add_a1_d;
      add_b0_q     <= add_b0_d;
      add_b1_q     <= add_b1_d;
      add_cin_q    <= add_cin_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_sum_q   <= rsp0_sum_d;
      rsp1_sum_q   <= rsp1_sum_d;
    end
  end

  assign add_a0     = add_a0_q;
  assign add_a1     = add_a1_q;
  assign add_b0     = add_b0_q;
  assign add_b1     = add_b1_q;
  assign add_cin    = add_cin_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_sum   = rsp0_sum_q;
  assign rsp1_sum   = rsp1_sum_q;
  assign busy       = (|tag_v_q) | rsp0_valid_q | rsp1_valid_q;

endmodule
